// File: rtl/bcd_countdown_timer.sv
// N-digit BCD round-clock countdown with run/pause control, saturating bonus add
// and optional auto-reload on expiry. All outputs are registered.
module bcd_countdown_timer #(
  parameter int          NUM_DIGITS  = 2,
  parameter int unsigned BONUS_SEC   = 5,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    onesec_in,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    reconfig,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    bonus_in,
  output logic [4*NUM_DIGITS-1:0] timer_out,
  output logic                    running,
  output logic                    time_out,
  output logic                    expire_pulse
);

  localparam int W = 4 * NUM_DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] BONUS_BCD = to_bcd(BONUS_SEC);
  localparam logic [W-1:0] MAX_BCD   = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  state_t       r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_load;
  logic         r_running;
  logic         r_time_out;
  logic         r_expire_pulse;

  logic [W-1:0]          w_load_clamped;
  logic [W-1:0]          w_sum;
  logic [W-1:0]          w_sum_sat;
  logic [W-1:0]          w_base;
  logic [W-1:0]          w_dec;
  logic [NUM_DIGITS:0]   w_carry;
  logic [NUM_DIGITS-1:0] w_borrow;
  logic                  w_dec_zero;

  assign w_carry[0]  = 1'b0;
  assign w_borrow[0] = 1'b1;

  // Per-digit: switch clamp, bonus add with decimal carry, decrement with decimal borrow.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [4:0] w_dsum;

      assign w_load_clamped[4*gi +: 4] =
        (load_val[4*gi +: 4] > 4'd9) ? 4'd9 : load_val[4*gi +: 4];

      assign w_dsum = {1'b0, r_count[4*gi +: 4]} + {1'b0, BONUS_BCD[4*gi +: 4]}
                    + {4'b0, w_carry[gi]};
      assign w_carry[gi+1]    = (w_dsum > 5'd9);
      assign w_sum[4*gi +: 4] = w_carry[gi+1] ? 4'(w_dsum - 5'd10) : w_dsum[3:0];

      assign w_dec[4*gi +: 4] =
        !w_borrow[gi]               ? w_base[4*gi +: 4] :
        (w_base[4*gi +: 4] == 4'd0) ? 4'd9 :
                                      w_base[4*gi +: 4] - 4'd1;

      if (gi < NUM_DIGITS - 1) begin : g_borrow
        assign w_borrow[gi+1] = w_borrow[gi] && (w_base[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  // A carry out of the top digit means the true sum exceeded the display range.
  assign w_sum_sat  = w_carry[NUM_DIGITS] ? MAX_BCD : w_sum;
  assign w_base     = bonus_in ? w_sum_sat : r_count;
  assign w_dec_zero = (w_dec == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_load         <= '0;
      r_running      <= 1'b0;
      r_time_out     <= 1'b0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_expire_pulse <= 1'b0;
      if (reconfig) begin
        r_state    <= S_IDLE;
        r_count    <= w_load_clamped;
        r_load     <= w_load_clamped;
        r_running  <= 1'b0;
        r_time_out <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (r_count == '0) begin
                r_state        <= S_EXPIRED;
                r_time_out     <= 1'b1;
                r_expire_pulse <= 1'b1;
              end else begin
                r_state   <= S_RUN;
                r_running <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (pause) begin
              // The tick of this cycle is dropped; a bonus still lands.
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
              if (bonus_in) r_count <= w_sum_sat;
            end else if (onesec_in) begin
              if (w_dec_zero) begin
                r_expire_pulse <= 1'b1;
                if (AUTO_RELOAD && (r_load != '0)) begin
                  r_count <= r_load;
                end else begin
                  r_count    <= '0;
                  r_state    <= S_EXPIRED;
                  r_running  <= 1'b0;
                  r_time_out <= 1'b1;
                end
              end else begin
                r_count <= w_dec;
              end
            end else if (bonus_in) begin
              r_count <= w_sum_sat;
            end
          end
          S_PAUSE: begin
            if (start) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
            if (bonus_in) r_count <= w_sum_sat;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign timer_out    = r_count;
  assign running      = r_running;
  assign time_out     = r_time_out;
  assign expire_pulse = r_expire_pulse;

endmodule
